// File: rtl/mips_core_pkg.sv
// Shared core types: branch outcome encoding and the in-flight branch record.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package mips_core_pkg;

  typedef enum logic {
    NOT_TAKEN = 1'b0,
    TAKEN     = 1'b1
  } BranchOutcome;

  typedef struct packed {
    logic [`ADDR_WIDTH-1:0] pc;
    BranchOutcome           prediction;
    logic [`ADDR_WIDTH-1:0] recovery_target;
  } branch_inflight_t;

endpackage

// File: rtl/branch_inflight_fifo.sv
// In-order circular queue of in-flight branches; clear wins over push/pop.
module branch_inflight_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = logic,
  localparam int PW      = $clog2(DEPTH),
  localparam int CW      = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  input  logic          clear,
  output entry_t        head,
  output logic [CW-1:0] count
);

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  // a pop frees a slot in the same cycle, so a full queue still accepts push+pop
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/branch_resolver.sv
// Resolves queued branch predictions against EX outcomes; drives predictor
// feedback and mispredict redirect. Optional stats: BRANCH_RESOLVER_STATS_EN.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module branch_resolver
  import mips_core_pkg::*;
#(
  parameter int  DEPTH      = 4,
  parameter int  ADDR_WIDTH = `ADDR_WIDTH,
  localparam int CW         = $clog2(DEPTH+1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push_valid,
  input  logic [ADDR_WIDTH-1:0] i_push_pc,
  input  BranchOutcome          i_push_prediction,
  input  logic [ADDR_WIDTH-1:0] i_push_recovery_target,
  output logic                  o_push_ready,
  input  logic                  i_res_valid,
  input  BranchOutcome          i_res_outcome,
  input  logic                  i_flush,
  output logic                  o_fb_valid,
  output logic [ADDR_WIDTH-1:0] o_fb_pc,
  output BranchOutcome          o_fb_prediction,
  output BranchOutcome          o_fb_outcome,
  output logic                  o_redirect_valid,
  output logic [ADDR_WIDTH-1:0] o_redirect_target,
  output logic [CW-1:0]         o_count,
  output logic                  o_underflow,
  output logic [31:0]           o_stat_branches,
  output logic [31:0]           o_stat_mispredicts
);

  branch_inflight_t head, push_entry;
  logic             res_hit, mispred;

  assign res_hit      = i_res_valid && (o_count != '0);
  assign mispred      = res_hit && (head.prediction != i_res_outcome);
  assign o_push_ready = (o_count != CW'(DEPTH));

  assign push_entry.pc              = i_push_pc;
  assign push_entry.prediction      = i_push_prediction;
  assign push_entry.recovery_target = i_push_recovery_target;

  // a mispredict squashes every younger entry, including a same-cycle push
  branch_inflight_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (branch_inflight_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (i_push_valid),
    .push_data (push_entry),
    .pop       (res_hit),
    .clear     (i_flush || mispred),
    .head      (head),
    .count     (o_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_fb_valid        <= 1'b0;
      o_fb_pc           <= '0;
      o_fb_prediction   <= NOT_TAKEN;
      o_fb_outcome      <= NOT_TAKEN;
      o_redirect_valid  <= 1'b0;
      o_redirect_target <= '0;
      o_underflow       <= 1'b0;
    end else begin
      o_fb_valid       <= res_hit;
      o_redirect_valid <= mispred && !i_flush;
      o_underflow      <= i_res_valid && (o_count == '0);
      if (res_hit) begin
        o_fb_pc         <= head.pc;
        o_fb_prediction <= head.prediction;
        o_fb_outcome    <= i_res_outcome;
      end
      if (mispred && !i_flush) o_redirect_target <= head.recovery_target;
    end
  end

`ifdef BRANCH_RESOLVER_STATS_EN
  logic [31:0] stat_br, stat_mp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_br <= '0;
      stat_mp <= '0;
    end else begin
      if (o_fb_valid && (stat_br != '1))       stat_br <= stat_br + 32'd1;
      if (o_redirect_valid && (stat_mp != '1)) stat_mp <= stat_mp + 32'd1;
    end
  end

  assign o_stat_branches    = stat_br;
  assign o_stat_mispredicts = stat_mp;
`else
  assign o_stat_branches    = '0;
  assign o_stat_mispredicts = '0;
`endif

endmodule
